// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl: parametrised image-window controller.
// Loads an IMG_W x IMG_H image from IROM into a local pixel buffer, then runs
// 3-bit commands on a 2x2 window (write-back, shift, average, mirror).
// Write-back streams the whole buffer to IRB and pulses done.
// Optional feature macro: LCD_WIN_WRAP_EN (shifts wrap inside the valid
// origin range instead of clamping at its limits).
module lcd_win_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_EN,
    output logic [AW-1:0] IROM_A,
    output logic          IRB_RW,
    output logic [DW-1:0] IRB_D,
    output logic [AW-1:0] IRB_A,
    output logic          busy,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    // Load counter must reach N+1 (IROM read latency plus capture cycle).
    localparam int CW = AW + 2;

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_UP    = 3'd1;
    localparam logic [2:0] CMD_DOWN  = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_AVG   = 3'd5;
    localparam logic [2:0] CMD_MIRX  = 3'd6;
    localparam logic [2:0] CMD_MIRY  = 3'd7;

    typedef enum logic [1:0] {
        S_LOAD,
        S_IDLE,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   load_cnt_reg, load_cnt_next;
    logic [XW-1:0]   x_reg, x_next;
    logic [YW-1:0]   y_reg, y_next;
    logic [2:0]      cmd_reg, cmd_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            irom_en_reg, irom_en_next;
    logic [AW-1:0]   irom_a_reg, irom_a_next;
    logic            irb_rw_reg, irb_rw_next;
    logic [AW-1:0]   irb_a_reg, irb_a_next;
    logic [DW-1:0]   irb_d_reg, irb_d_next;

    // Pixel buffer, gathered from the per-pixel cells below.
    logic [DW-1:0]   pix_arr [N];

    // Buffer write controls produced by the FSM.
    logic            load_we;
    logic [AW-1:0]   load_idx;
    logic            exec_we;

    // Window addresses, current pixels and their replacement values.
    logic [AW-1:0]   a00, a01, a10, a11;
    logic [DW-1:0]   p00, p01, p10, p11;
    logic [DW-1:0]   n00, n01, n10, n11;
    logic [DW+1:0]   win_sum;
    logic [DW-1:0]   win_avg;

    // Window geometry: top-left pixel is (X-1, Y-1).
    always_comb begin
        a00 = AW'((int'(y_reg) - 1) * IMG_W + int'(x_reg) - 1);
        a01 = a00 + AW'(1);
        a10 = a00 + AW'(IMG_W);
        a11 = a10 + AW'(1);
        p00 = pix_arr[a00];
        p01 = pix_arr[a01];
        p10 = pix_arr[a10];
        p11 = pix_arr[a11];
        win_sum = {2'b00, p00} + {2'b00, p01} + {2'b00, p10} + {2'b00, p11};
        win_avg = win_sum[DW+1:2];
    end

    // State and output registers; reset aborts whatever is in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_LOAD;
            load_cnt_reg <= '0;
            x_reg        <= XW'(IMG_W / 2);
            y_reg        <= YW'(IMG_H / 2);
            cmd_reg      <= CMD_WRITE;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
            irom_en_reg  <= 1'b1;
            irom_a_reg   <= '0;
            irb_rw_reg   <= 1'b1;
            irb_a_reg    <= '0;
            irb_d_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            load_cnt_reg <= load_cnt_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            cmd_reg      <= cmd_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            irom_en_reg  <= irom_en_next;
            irom_a_reg   <= irom_a_next;
            irb_rw_reg   <= irb_rw_next;
            irb_a_reg    <= irb_a_next;
            irb_d_reg    <= irb_d_next;
        end
    end

    // Next-state, next-output and buffer-write decode.
    always_comb begin
        state_next    = state_reg;
        load_cnt_next = load_cnt_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        cmd_next      = cmd_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        irom_en_next  = irom_en_reg;
        irom_a_next   = irom_a_reg;
        irb_rw_next   = irb_rw_reg;
        irb_a_next    = irb_a_reg;
        irb_d_next    = irb_d_reg;
        load_we       = 1'b0;
        load_idx      = '0;
        exec_we       = 1'b0;
        n00           = p00;
        n01           = p01;
        n10           = p10;
        n11           = p11;

        case (state_reg)
            S_LOAD: begin
                // Address phase covers counts 0..N-1; data for count k
                // arrives two counts later, so capture trails by two.
                if (load_cnt_reg < CW'(N)) begin
                    irom_en_next = 1'b0;
                    irom_a_next  = AW'(load_cnt_reg);
                end else begin
                    irom_en_next = 1'b1;
                    irom_a_next  = '0;
                end
                if (load_cnt_reg >= CW'(2)) begin
                    load_we  = 1'b1;
                    load_idx = AW'(load_cnt_reg - CW'(2));
                end
                load_cnt_next = load_cnt_reg + CW'(1);
                if (load_cnt_reg == CW'(N + 1)) begin
                    state_next    = S_IDLE;
                    busy_next     = 1'b0;
                    load_cnt_next = '0;
                end
            end

            S_IDLE: begin
                if (cmd_valid) begin
                    busy_next = 1'b1;
                    cmd_next  = cmd;
                    if (cmd == CMD_WRITE) begin
                        state_next  = S_WRITE;
                        irb_rw_next = 1'b0;
                        irb_a_next  = '0;
                        irb_d_next  = pix_arr[0];
                    end else begin
                        state_next = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
                case (cmd_reg)
                    CMD_UP: begin
                        if (y_reg > YW'(1))
                            y_next = y_reg - YW'(1);
`ifdef LCD_WIN_WRAP_EN
                        else
                            y_next = YW'(IMG_H - 1);
`endif
                    end
                    CMD_DOWN: begin
                        if (y_reg < YW'(IMG_H - 1))
                            y_next = y_reg + YW'(1);
`ifdef LCD_WIN_WRAP_EN
                        else
                            y_next = YW'(1);
`endif
                    end
                    CMD_LEFT: begin
                        if (x_reg > XW'(1))
                            x_next = x_reg - XW'(1);
`ifdef LCD_WIN_WRAP_EN
                        else
                            x_next = XW'(IMG_W - 1);
`endif
                    end
                    CMD_RIGHT: begin
                        if (x_reg < XW'(IMG_W - 1))
                            x_next = x_reg + XW'(1);
`ifdef LCD_WIN_WRAP_EN
                        else
                            x_next = XW'(1);
`endif
                    end
                    CMD_AVG: begin
                        exec_we = 1'b1;
                        n00     = win_avg;
                        n01     = win_avg;
                        n10     = win_avg;
                        n11     = win_avg;
                    end
                    CMD_MIRX: begin
                        exec_we = 1'b1;
                        n00     = p10;
                        n01     = p11;
                        n10     = p00;
                        n11     = p01;
                    end
                    CMD_MIRY: begin
                        exec_we = 1'b1;
                        n00     = p01;
                        n01     = p00;
                        n10     = p11;
                        n11     = p10;
                    end
                    default: begin
                    end
                endcase
            end

            S_WRITE: begin
                if (irb_a_reg == AW'(N - 1)) begin
                    state_next  = S_IDLE;
                    irb_rw_next = 1'b1;
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                end else begin
                    irb_a_next = irb_a_reg + AW'(1);
                    irb_d_next = pix_arr[irb_a_reg + AW'(1)];
                end
            end

            default: begin
                state_next = S_LOAD;
            end
        endcase
    end

    // One storage cell per pixel; the four window addresses are always
    // distinct, so at most one window update hits a given cell.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pix
            logic [DW-1:0] pix_q;

            // Capture IROM data during load, or the window result in EXEC.
            always_ff @(posedge clk) begin
                if (load_we && (load_idx == AW'(gi))) begin
                    pix_q <= IROM_Q;
                end else if (exec_we) begin
                    if (a00 == AW'(gi))
                        pix_q <= n00;
                    else if (a01 == AW'(gi))
                        pix_q <= n01;
                    else if (a10 == AW'(gi))
                        pix_q <= n10;
                    else if (a11 == AW'(gi))
                        pix_q <= n11;
                end
            end

            assign pix_arr[gi] = pix_q;
        end
    endgenerate

    assign IROM_EN = irom_en_reg;
    assign IROM_A  = irom_a_reg;
    assign IRB_RW  = irb_rw_reg;
    assign IRB_D   = irb_d_reg;
    assign IRB_A   = irb_a_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Directed testbench for lcd_win_ctrl: an 8x8x8 instance (IROM[i]=i) and a
// 16x4x10 instance (IROM[i]=1023-i), each with IROM and IRB models.
module tb_lcd_win_ctrl;

    localparam int N = 64;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8x8, DW=8 instance
    logic       rst1 = 1'b1;
    logic [2:0] cmd1 = 3'd0;
    logic       cv1  = 1'b0;
    logic [7:0] q1   = 8'd0;
    logic       en1, rw1, busy1, done1;
    logic [5:0] ia1, ba1;
    logic [7:0] d1;

    // 16x4, DW=10 instance
    logic       rst2 = 1'b1;
    logic [2:0] cmd2 = 3'd0;
    logic       cv2  = 1'b0;
    logic [9:0] q2   = 10'd0;
    logic       en2, rw2, busy2, done2;
    logic [5:0] ia2, ba2;
    logic [9:0] d2;

    logic [7:0] irb1 [N];
    logic [9:0] irb2 [N];
    int done_cnt1 = 0;
    int done_cnt2 = 0;

    lcd_win_ctrl #(.IMG_W(8), .IMG_H(8), .DW(8), .AW(6)) u_dut1 (
        .clk(clk), .reset(rst1), .cmd(cmd1), .cmd_valid(cv1), .IROM_Q(q1),
        .IROM_EN(en1), .IROM_A(ia1), .IRB_RW(rw1), .IRB_D(d1), .IRB_A(ba1),
        .busy(busy1), .done(done1)
    );

    lcd_win_ctrl #(.IMG_W(16), .IMG_H(4), .DW(10), .AW(6)) u_dut2 (
        .clk(clk), .reset(rst2), .cmd(cmd2), .cmd_valid(cv2), .IROM_Q(q2),
        .IROM_EN(en2), .IROM_A(ia2), .IRB_RW(rw2), .IRB_D(d2), .IRB_A(ba2),
        .busy(busy2), .done(done2)
    );

    // Synchronous IROM, IRB and done-pulse counters
    always @(posedge clk) begin
        if (!en1) q1 <= {2'b00, ia1};
        if (!rw1) irb1[ba1] <= d1;
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if (!en2) q2 <= 10'(1023 - int'(ia2));
        if (!rw2) irb2[ba2] <= d2;
        if (done2) done_cnt2 <= done_cnt2 + 1;
    end

    // Issue one command; lat = edges from acceptance until busy falls (-1 if never idle)
    task automatic issue(input int sel, input logic [2:0] c, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (((sel == 1) ? busy1 : busy2) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sel == 1) begin cmd1 = c; cv1 = 1'b1; end
        else          begin cmd2 = c; cv2 = 1'b1; end
        @(posedge clk);
        #1;
        cv1 = 1'b0;
        cv2 = 1'b0;
        lat = 0;
        while (((sel == 1) ? busy1 : busy2) && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (t >= 300) lat = -1;
    endtask

    // Pulse reset and wait for load to finish; edges = clock edges until busy falls
    task automatic do_reset(input int sel, output int edges);
        @(negedge clk);
        if (sel == 1) rst1 = 1'b1; else rst2 = 1'b1;
        repeat (2) @(negedge clk);
        if (sel == 1) rst1 = 1'b0; else rst2 = 1'b0;
        edges = 0;
        while (((sel == 1) ? busy1 : busy2) && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        int bad;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy1, done1, en1, rw1} !== 4'b1011) begin
            errors++;
            $display("FAIL reset_ctrl: busy,done,en,rw got %b expected 1011", {busy1, done1, en1, rw1});
        end
        checks++;
        if (ia1 !== 6'd0 || ba1 !== 6'd0 || d1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_bus: IROM_A=%0d IRB_A=%0d IRB_D=%0d expected 0 0 0", ia1, ba1, d1);
        end
        rst1 = 1'b0;
        bad = 0;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk);
            #1;
            if (busy1 !== 1'b1) bad++;
            if (k <= N && (en1 !== 1'b0 || ia1 !== 6'(k - 1))) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL load_sequence: %0d bad cycles expected 0", bad);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b0 || en1 !== 1'b1) begin
            errors++;
            $display("FAIL load_end: busy=%b en=%b expected busy 0 en 1", busy1, en1);
        end
        $display("reset/load: busy released after %0d edges", N + 2);
    endtask

    task automatic test_writeback();
        int lat, cnt0, bad;
        cnt0 = done_cnt1;
        issue(1, 3'd0, lat);
        checks++;
        if (lat != N) begin
            errors++;
            $display("FAIL write_latency: got %0d expected %0d", lat, N);
        end
        checks++;
        if (done1 !== 1'b1 || rw1 !== 1'b1) begin
            errors++;
            $display("FAIL write_done: done=%b rw=%b expected 1 1", done1, rw1);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt1 - cnt0 != 1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL write_done_pulse: pulses=%0d done=%b expected 1 0", done_cnt1 - cnt0, done1);
        end
        bad = 0;
        for (int i = 0; i < N; i++) if (irb1[i] !== 8'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL write_image: %0d wrong pixels expected 0", bad);
        end
        $display("write-back: latency %0d", lat);
    endtask

    task automatic test_average();
        int lat, lat2;
        issue(1, 3'd5, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL avg_busy: got %0d expected 1", lat);
        end
        issue(1, 3'd0, lat2);
        checks++;
        if (irb1[27] !== 8'd31 || irb1[28] !== 8'd31 || irb1[35] !== 8'd31 || irb1[36] !== 8'd31) begin
            errors++;
            $display("FAIL avg_window: got %0d %0d %0d %0d expected 31 31 31 31",
                     irb1[27], irb1[28], irb1[35], irb1[36]);
        end
        checks++;
        if (irb1[26] !== 8'd26 || irb1[37] !== 8'd37 || irb1[19] !== 8'd19) begin
            errors++;
            $display("FAIL avg_neighbours: got %0d %0d %0d expected 26 37 19", irb1[26], irb1[37], irb1[19]);
        end
        $display("average at (4,4): write latency %0d", lat2);
    endtask

    task automatic test_reset_abort();
        int edges, cnt0, bad;
        edges = 0;
        do_reset(1, edges);
        checks++;
        if (edges != N + 2) begin
            errors++;
            $display("FAIL reload_time: got %0d expected %0d", edges, N + 2);
        end
        cnt0 = done_cnt1;
        @(negedge clk);
        cmd1 = 3'd0;
        cv1  = 1'b1;
        @(posedge clk);
        #1;
        cv1 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst1 = 1'b1;
        #1;
        checks++;
        if ({busy1, done1, en1, rw1} !== 4'b1011 || ia1 !== 6'd0 || ba1 !== 6'd0 || d1 !== 8'd0) begin
            errors++;
            $display("FAIL abort_reset_values: busy,done,en,rw=%b A=%0d IRB_A=%0d D=%0d expected 1011 0 0 0",
                     {busy1, done1, en1, rw1}, ia1, ba1, d1);
        end
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        bad = 0;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk);
            #1;
            if (busy1 !== 1'b1 || done1 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_busy_hold: %0d bad cycles expected 0", bad);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b0 || done_cnt1 != cnt0) begin
            errors++;
            $display("FAIL abort_no_done: busy=%b pulses=%0d expected 0 0", busy1, done_cnt1 - cnt0);
        end
        checks++;
        if (irb1[19] !== 8'd19 || irb1[27] !== 8'd31) begin
            errors++;
            $display("FAIL abort_partial_irb: irb19=%0d irb27=%0d expected 19 31", irb1[19], irb1[27]);
        end
        $display("reset at write cycle 20: aborted, reload done");
    endtask

    task automatic test_mirror();
        int edges, lat6, lat7, latw;
        do_reset(1, edges);
        issue(1, 3'd6, lat6);
        issue(1, 3'd7, lat7);
        issue(1, 3'd0, latw);
        checks++;
        if (lat6 != 1 || lat7 != 1 || latw != N) begin
            errors++;
            $display("FAIL mirror_latency: got %0d %0d %0d expected 1 1 %0d", lat6, lat7, latw, N);
        end
        checks++;
        if (irb1[27] !== 8'd36 || irb1[28] !== 8'd35 || irb1[35] !== 8'd28 || irb1[36] !== 8'd27) begin
            errors++;
            $display("FAIL mirror_window: got %0d %0d %0d %0d expected 36 35 28 27",
                     irb1[27], irb1[28], irb1[35], irb1[36]);
        end
        $display("mirror X then Y at (4,4): window %0d %0d %0d %0d", irb1[27], irb1[28], irb1[35], irb1[36]);
    endtask

    task automatic test_shift_left();
        int edges, lat, bad, exp_v;
        int ea [4];
`ifdef LCD_WIN_WRAP_EN
        ea = '{29, 30, 37, 38};
        exp_v = 33;
`else
        ea = '{24, 25, 32, 33};
        exp_v = 28;
`endif
        do_reset(1, edges);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            issue(1, 3'd3, lat);
            if (lat != 1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL shift_busy: %0d shifts not 1 cycle expected 0", bad);
        end
        issue(1, 3'd5, lat);
        issue(1, 3'd0, lat);
        bad = 0;
        for (int j = 0; j < 4; j++) if (irb1[ea[j]] !== 8'(exp_v)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL shift_avg_window: got %0d %0d %0d %0d expected %0d",
                     irb1[ea[0]], irb1[ea[1]], irb1[ea[2]], irb1[ea[3]], exp_v);
        end
        checks++;
        if (irb1[27] !== 8'd27 || irb1[36] !== 8'd36) begin
            errors++;
            $display("FAIL shift_old_window: got %0d %0d expected 27 36", irb1[27], irb1[36]);
        end
        $display("5x left then average: window value %0d", irb1[ea[0]]);
    endtask

    task automatic test_param2();
        int edges, lat, cnt0, bad;
        do_reset(2, edges);
        checks++;
        if (edges != N + 2) begin
            errors++;
            $display("FAIL p2_load_time: got %0d expected %0d", edges, N + 2);
        end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            issue(2, 3'd2, lat);
            if (lat != 1) bad++;
        end
        issue(2, 3'd5, lat);
        if (lat != 1) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL p2_exec_busy: %0d commands not 1 cycle expected 0", bad);
        end
        cnt0 = done_cnt2;
        issue(2, 3'd0, lat);
        checks++;
        if (lat != N || done2 !== 1'b1) begin
            errors++;
            $display("FAIL p2_write: latency=%0d done=%b expected %0d 1", lat, done2, N);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt2 - cnt0 != 1) begin
            errors++;
            $display("FAIL p2_done_pulse: got %0d expected 1", done_cnt2 - cnt0);
        end
        checks++;
        if (irb2[39] !== 10'd975 || irb2[40] !== 10'd975 || irb2[55] !== 10'd975 || irb2[56] !== 10'd975) begin
            errors++;
            $display("FAIL p2_window: got %0d %0d %0d %0d expected 975",
                     irb2[39], irb2[40], irb2[55], irb2[56]);
        end
        checks++;
        if (irb2[0] !== 10'd1023 || irb2[38] !== 10'd985 || irb2[63] !== 10'd960) begin
            errors++;
            $display("FAIL p2_neighbours: got %0d %0d %0d expected 1023 985 960", irb2[0], irb2[38], irb2[63]);
        end
        $display("16x4: 3x down, average, write: window %0d", irb2[39]);
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_average();
        test_reset_abort();
        test_mirror();
        test_shift_left();
        test_param2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
